// File: rtl/prog_loader.sv
// prog_loader: push-button program loader for the CPU RAM write port.
// Hex digits are shifted into a 32-bit entry word. Each commit writes that
// word to the next word address. While loading, the core is held in reset;
// a run command releases the RAM port and enables the core.
// Optional feature: define PROG_LOADER_DEBOUNCE_EN to put a per-button
// debounce counter between the synchronizer and the edge detector.
module prog_loader #(
    parameter int MEM_BYTES       = 4096,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] pb,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_en,
    output logic        cpu_rst,
    output logic [31:0] disp_value,
    output logic        full
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);

    localparam int BTN_COMMIT = 16;
    localparam int BTN_CLEAR  = 17;
    localparam int BTN_RUN    = 18;
    localparam int BTN_LOAD   = 19;

    // Reject parameter values that cannot describe a working loader.
    if (MEM_BYTES < 4 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("prog_loader: MEM_BYTES must be >= 4 and DEBOUNCE_CYCLES >= 1");
    end

    logic [19:0] sync1_reg;
    logic [19:0] sync2_reg;
    logic [1:0]  warm_reg;
    logic [19:0] arm_reg;
    logic [19:0] level;
    logic [19:0] prev_reg;
    logic [19:0] pulse_reg;

    state_t      state_reg, state_next;
    logic [31:0] entry_reg, entry_next;
    logic [31:0] addr_reg, addr_next;
    logic        full_reg, full_next;

    logic        digit_hit;
    logic [3:0]  digit_val;

    // Two-flop synchronizer plus arming. A button only becomes eligible for
    // a press once it has been seen released after the synchronizer has
    // filled, so a button held across reset never produces a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            warm_reg  <= '0;
            arm_reg   <= '0;
        end else begin
            sync1_reg <= pb;
            sync2_reg <= sync1_reg;
            warm_reg  <= {warm_reg[0], 1'b1};
            arm_reg   <= arm_reg | ({20{warm_reg[1]}} & ~sync2_reg);
        end
    end

`ifdef PROG_LOADER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    genvar gi;
    for (gi = 0; gi < 20; gi++) begin : g_db
        logic [CW-1:0] cnt_reg;
        logic          db_reg;

        // Debounced level follows the synchronized input only after it has
        // disagreed for DEBOUNCE_CYCLES consecutive samples.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
                db_reg  <= 1'b0;
            end else if (sync2_reg[gi] == db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_reg  <= sync2_reg[gi];
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end

        assign level[gi] = db_reg;
    end
`else
    genvar gi;
    for (gi = 0; gi < 20; gi++) begin : g_nodb
        assign level[gi] = sync2_reg[gi];
    end
`endif

    // Rising-edge detector: registered one-cycle pulse per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg  <= '0;
            pulse_reg <= '0;
        end else begin
            prev_reg  <= level;
            pulse_reg <= level & ~prev_reg & arm_reg;
        end
    end

    // Digit decode: scanning downward lets the lowest pressed digit win.
    always_comb begin
        digit_hit = 1'b0;
        digit_val = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pulse_reg[i]) begin
                digit_hit = 1'b1;
                digit_val = 4'(i);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LOAD;
            entry_reg <= '0;
            addr_reg  <= '0;
            full_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            entry_reg <= entry_next;
            addr_reg  <= addr_next;
            full_reg  <= full_next;
        end
    end

    // Next-state logic: one action per cycle, run > commit > clear > digit.
    always_comb begin
        state_next = state_reg;
        entry_next = entry_reg;
        addr_next  = addr_reg;
        full_next  = full_reg;
        case (state_reg)
            LOAD: begin
                if (pulse_reg[BTN_RUN]) begin
                    state_next = RUN;
                end else if (pulse_reg[BTN_COMMIT]) begin
                    // A commit while full still wins priority but does nothing.
                    if (!full_reg) begin
                        state_next = WRITE;
                    end
                end else if (pulse_reg[BTN_CLEAR]) begin
                    entry_next = '0;
                end else if (digit_hit) begin
                    entry_next = {entry_reg[27:0], digit_val};
                end
            end
            WRITE: begin
                state_next = LOAD;
                entry_next = '0;
                if (addr_reg == LAST_ADDR) begin
                    full_next = 1'b1;
                end else begin
                    addr_next = addr_reg + 32'd4;
                end
            end
            RUN: begin
                if (pulse_reg[BTN_LOAD]) begin
                    state_next = LOAD;
                    entry_next = '0;
                    addr_next  = '0;
                    full_next  = 1'b0;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        mem_en  = (state_reg != RUN);
        mem_we  = (state_reg == WRITE);
        cpu_en  = (state_reg == RUN);
        cpu_rst = (state_reg != RUN);
    end

    assign mem_addr   = addr_reg;
    assign mem_wdata  = entry_reg;
    assign disp_value = entry_reg;
    assign full       = full_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: a table of button presses with expected
// outputs, plus hand-written sequences for write latency and reset abort.
module tb_prog_loader;

`ifdef PROG_LOADER_DEBOUNCE_EN
    localparam int EXTRA = 16;
    localparam int HOLD  = 18;
`else
    localparam int EXTRA = 0;
    localparam int HOLD  = 1;
`endif
    localparam int SETTLE = 6 + EXTRA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] pb  = '0;
    logic        mem_en, mem_we, cpu_en, cpu_rst, full;
    logic [31:0] mem_addr, mem_wdata, disp_value;

    int total = 0;
    int bad   = 0;
    int nwr   = 0;
    logic [31:0] last_waddr = '0;
    logic [31:0] last_wdata = '0;

    prog_loader #(.MEM_BYTES(16), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .pb(pb),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_en(cpu_en), .cpu_rst(cpu_rst),
        .disp_value(disp_value), .full(full)
    );

    always #5 clk = ~clk;

    // Write monitor: logs every RAM write strobe.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            nwr        = nwr + 1;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [19:0] mask;
        bit          long_hold;
        logic [31:0] disp;
        logic [31:0] addr;
        bit          full;
        bit          run;
        int          nwr;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [19:0] m, input bit lh, input logic [31:0] d,
                       input logic [31:0] a, input bit f, input bit r, input int n,
                       input logic [31:0] wa, input logic [31:0] wd);
        vec_t v;
        v.mask = m; v.long_hold = lh; v.disp = d; v.addr = a; v.full = f;
        v.run = r; v.nwr = n; v.waddr = wa; v.wdata = wd;
        tbl.push_back(v);
    endtask

    task automatic press(input logic [19:0] m, input int hold);
        @(posedge clk);
        #1 pb = m;
        repeat (hold) @(posedge clk);
        #1 pb = '0;
        repeat (SETTLE) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply(input int idx);
        vec_t v;
        v = tbl[idx];
        press(v.mask, v.long_hold ? HOLD + 8 : HOLD);
        $display("vec %0d mask=%h disp=%h addr=%h full=%b cpu_en=%b nwr=%0d",
                 idx, v.mask, disp_value, mem_addr, full, cpu_en, nwr);
        chk($sformatf("v%0d_disp", idx), disp_value, v.disp);
        chk($sformatf("v%0d_addr", idx), mem_addr, v.addr);
        chk($sformatf("v%0d_full", idx), 32'(full), 32'(v.full));
        chk($sformatf("v%0d_mem_en", idx), 32'(mem_en), 32'(!v.run));
        chk($sformatf("v%0d_cpu_en", idx), 32'(cpu_en), 32'(v.run));
        chk($sformatf("v%0d_cpu_rst", idx), 32'(cpu_rst), 32'(!v.run));
        chk($sformatf("v%0d_nwr", idx), 32'(nwr), 32'(v.nwr));
        chk($sformatf("v%0d_waddr", idx), last_waddr, v.waddr);
        chk($sformatf("v%0d_wdata", idx), last_wdata, v.wdata);
    endtask

    // Presses commit and stops at the negedge of the WRITE cycle, checking
    // that the strobe is low one cycle earlier and high exactly on time.
    task automatic commit_to_write(input string tag);
        @(posedge clk);
        #1 pb = 20'h10000;
        for (int i = 0; i < 3 + EXTRA; i++) begin
            @(posedge clk);
            if (i == HOLD - 1) #1 pb = '0;
        end
        pb = '0;
        @(negedge clk);
        chk({tag, "_we_early"}, 32'(mem_we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        $display("%s write addr=%h data=%h we=%b", tag, mem_addr, mem_wdata, mem_we);
        chk({tag, "_we"}, 32'(mem_we), 32'd1);
    endtask

    initial begin
        logic [31:0] e_exp;

        // Table: digits 1..8 (rows 0-7), then the rest after the first commit.
        add(20'h00002, 0, 32'h00000001, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        add(20'h00004, 0, 32'h00000012, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        add(20'h00008, 0, 32'h00000123, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        add(20'h00010, 0, 32'h00001234, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        add(20'h00020, 0, 32'h00012345, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        add(20'h00040, 0, 32'h00123456, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        add(20'h00080, 0, 32'h01234567, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        add(20'h00100, 0, 32'h12345678, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        add(20'h00204, 0, 32'h2, 32'h4, 0, 0, 1, 32'h0, 32'h12345678); // digits 2+9: 2 wins
        add(20'h20000, 0, 32'h0, 32'h4, 0, 0, 1, 32'h0, 32'h12345678); // clear
        add(20'h00400, 0, 32'hA, 32'h4, 0, 0, 1, 32'h0, 32'h12345678);
        add(20'h30000, 0, 32'h0, 32'h8, 0, 0, 2, 32'h4, 32'hA);        // commit beats clear
        add(20'h00008, 1, 32'h3, 32'h8, 0, 0, 2, 32'h4, 32'hA);        // long hold, one digit
        add(20'h10000, 0, 32'h0, 32'hC, 0, 0, 3, 32'h8, 32'h3);
        add(20'h08000, 0, 32'hF, 32'hC, 0, 0, 3, 32'h8, 32'h3);
        add(20'h10000, 0, 32'h0, 32'hC, 1, 0, 4, 32'hC, 32'hF);        // last word, full
        add(20'h00080, 0, 32'h7, 32'hC, 1, 0, 4, 32'hC, 32'hF);
        add(20'h10000, 0, 32'h7, 32'hC, 1, 0, 4, 32'hC, 32'hF);        // commit while full
        add(20'h40000, 0, 32'h7, 32'hC, 1, 1, 4, 32'hC, 32'hF);        // run
        add(20'h00002, 0, 32'h7, 32'hC, 1, 1, 4, 32'hC, 32'hF);        // digit ignored
        add(20'h10000, 0, 32'h7, 32'hC, 1, 1, 4, 32'hC, 32'hF);        // commit ignored
        add(20'h20000, 0, 32'h7, 32'hC, 1, 1, 4, 32'hC, 32'hF);        // clear ignored
        add(20'h80000, 0, 32'h0, 32'h0, 0, 0, 4, 32'hC, 32'hF);        // back to load
        add(20'h00020, 0, 32'h5, 32'h0, 0, 0, 4, 32'hC, 32'hF);
        add(20'h50000, 0, 32'h5, 32'h0, 0, 1, 4, 32'hC, 32'hF);        // run beats commit
        add(20'h80000, 0, 32'h0, 32'h0, 0, 0, 4, 32'hC, 32'hF);
        add(20'h80000, 0, 32'h0, 32'h0, 0, 0, 4, 32'hC, 32'hF);        // load while loading
        add(20'h01040, 0, 32'h6, 32'h0, 0, 0, 4, 32'hC, 32'hF);        // digits 6+C: 6 wins
        add(20'h20008, 0, 32'h0, 32'h0, 0, 0, 4, 32'hC, 32'hF);        // clear beats digit

        // Reset with pb[3] held: no digit may be entered afterwards.
        pb = 20'h00008;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        $display("reset disp=%h mem_en=%b cpu_en=%b cpu_rst=%b", disp_value, mem_en, cpu_en, cpu_rst);
        chk("rst_disp", disp_value, 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'd1);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_nwr", 32'(nwr), 32'd0);
        pb = '0;
        repeat (SETTLE + EXTRA) @(posedge clk);

        for (int i = 0; i < 8; i++) apply(i);

        // First commit with exact strobe timing.
        commit_to_write("c1");
        chk("c1_addr", mem_addr, 32'h0);
        chk("c1_wdata", mem_wdata, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        chk("c1_we_after", 32'(mem_we), 32'd0);
        chk("c1_addr_next", mem_addr, 32'h4);
        chk("c1_disp_next", disp_value, 32'h0);
        chk("c1_nwr", 32'(nwr), 32'd1);

        for (int i = 8; i < tbl.size(); i++) apply(i);

        e_exp = 32'h9;
`ifdef PROG_LOADER_DEBOUNCE_EN
        // Short glitch is filtered, a long press counts once.
        press(20'h00020, 10);
        $display("glitch disp=%h", disp_value);
        chk("db_glitch", disp_value, 32'h0);
        press(20'h00020, 20);
        $display("long press disp=%h", disp_value);
        chk("db_press", disp_value, 32'h5);
        e_exp = 32'h59;
`endif

        // Reset during WRITE aborts the write.
        press(20'h00200, HOLD);
        $display("pre-abort disp=%h", disp_value);
        chk("ab_disp", disp_value, e_exp);
        commit_to_write("ab");
        chk("ab_wdata", mem_wdata, e_exp);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        $display("abort we=%b addr=%h disp=%h", mem_we, mem_addr, disp_value);
        chk("ab_we", 32'(mem_we), 32'd0);
        chk("ab_disp_rst", disp_value, 32'h0);
        chk("ab_cpu_rst", 32'(cpu_rst), 32'd1);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ab_addr", mem_addr, 32'h0);
        chk("ab_nwr", 32'(nwr), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Button-driven program loader that sits upstream of the CPU data/instruction RAM write port. While in load mode it owns the RAM: hex digits entered on push-buttons are assembled into 32-bit words and written to consecutive word addresses. It holds the core in reset, then releases the RAM and enables the core on a run command. Its outputs drive the RAM-port muxes (address/data/write-enable select) and the CPU enable/reset gating.

## Interface
Parameters:
- `MEM_BYTES`, 4096: RAM size in bytes; last writable word is `MEM_BYTES-4`.
- `DEBOUNCE_CYCLES`, 16: stable cycles required per button (used only with the debounce macro).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `pb` in 20: raw push-buttons.
  - `[15:0]` hex digit 0..F.
  - `[16]` commit word.
  - `[17]` clear entry.
  - `[18]` run.
  - `[19]` return to load.
- `mem_en` out 1: 1 = loader owns RAM port (mux select).
- `mem_we` out 1: RAM write strobe.
- `mem_addr` out 32: byte address of write.
- `mem_wdata` out 32: word to write.
- `cpu_en` out 1: PC advance enable.
- `cpu_rst` out 1: active-high hold-reset for register file and PC.
- `disp_value` out 32: current entry word, for the seven-segment driver.
- `full` out 1: last word written; further commits ignored.

## Operation
- **Input stage:** each `pb` bit goes through a 2-flop synchronizer, then a rising-edge detector, giving a one-cycle pulse per press. Holding a button produces no repeats.
- **States:** LOAD, WRITE, RUN.
- **LOAD**
  - Outputs: `mem_en=1`, `cpu_en=0`, `cpu_rst=1`.
  - Digit pulse: `entry <= {entry[27:0], d}`. If several digit pulses arrive in one cycle, the lowest index wins.
  - Clear pulse: `entry <= 0`.
  - Commit pulse with `full=0`: go to WRITE. Commit pulse with `full=1`: ignored.
  - Run pulse: go to RUN.
  - Priority when pulses coincide: run > commit > clear > digit. Only the winning action is taken.
- **WRITE** (exactly 1 cycle)
  - `mem_we=1`, `mem_wdata=entry`, `mem_addr=addr`.
  - Next cycle:
    - If `addr == MEM_BYTES-4`, set `full=1` and keep `addr`. Otherwise `addr <= addr+4`.
    - `entry <= 0`; return to LOAD.
  - All button pulses arriving during WRITE are dropped.
- **RUN**
  - Outputs: `mem_en=0`, `mem_we=0`, `cpu_en=1`, `cpu_rst=0`.
  - Only pb[19] is honoured. On it: go to LOAD with `addr=0`, `entry=0`, `full=0`, and `cpu_rst` reasserted.
- `mem_we` is 1 only in WRITE.
- `mem_addr` always reflects `addr`; `mem_wdata` always reflects `entry`.
- `disp_value = entry`.

## Timing
- **Reset values:** state=LOAD, `addr=0`, `entry=0`, `full=0`, `mem_en=1`, `mem_we=0`, `cpu_en=0`, `cpu_rst=1`. Synchronizer and edge flops are cleared, so a button already held at reset release does not generate a pulse.
- **Latency (no debounce)**
  - A `pb` level change at edge N appears as a pulse in cycle N+2.
  - The state/entry update is visible at edge N+3.
  - The commit's `mem_we` is high for exactly one cycle, starting at edge N+3.
- **Run release:** `cpu_rst` deasserts and `cpu_en` asserts on the same edge the state enters RUN. The core sees its first fetch from address 0 on the following cycle.
- **Reset mid-operation:** `rst` during WRITE aborts the write; `mem_we` is 0 on the next edge.
- **Address width:** `addr[31:0]`, always word-aligned; bits `[1:0]` are always 0.

## Configuration
- `PROG_LOADER_DEBOUNCE_EN` defined:
  - Each synchronized bit feeds a per-button counter.
  - The debounced level updates only after `DEBOUNCE_CYCLES` consecutive identical samples.
  - The edge detector runs on the debounced level.
  - Added latency is `DEBOUNCE_CYCLES` cycles.
  - Glitches shorter than `DEBOUNCE_CYCLES` produce no pulse.
- Undefined: synchronizer and edge detector only; any pulse of 1 or more cycles counts as a press.

## Test plan
- **Reset:** assert `rst` 2 cycles with pb[3] held, release → `mem_en=1`, `cpu_rst=1`, `cpu_en=0`, `disp_value=0`, no digit entered.
- **Entry and write:** press digits 1,2,3,4,5,6,7,8 then pb[16] → one cycle with `mem_we=1`, `mem_addr=0`, `mem_wdata=32'h12345678`. Then `mem_addr=4`, `disp_value=0`.
- **Priority:** pulse pb[2] and pb[9] together → entry gets 2. Pulse pb[16] and pb[17] together with `entry=32'hA` → write of `32'hA` occurs, no clear first.
- **Full:** with `MEM_BYTES=16`, commit 4 words → addresses 0,4,8,12 and `full=1`. A 5th commit → no `mem_we`, `addr` stays 12.
- **Run/return:** after loading, pb[18] → `mem_en=0`, `cpu_en=1`, `cpu_rst=0`. Digit and commit presses are ignored. pb[19] → LOAD with `addr=0`, `cpu_rst=1`.
- **Debounce (macro on, `DEBOUNCE_CYCLES=16`):** a 10-cycle pulse on pb[5] → no entry change. A 20-cycle press → entry gets 5, exactly once.
